// File: rtl/arb4_sched_if.sv
// Request/grant bundle for the four-way arbiter.
// The master side drives requests; the slave (arbiter) side returns grants.
interface arb4_sched_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/arb4_sched.sv
// Four-requester arbiter with a hold limit and a guaranteed dead cycle between grants.
// Define ROUND_ROBIN_EN for rotating priority; otherwise req[3] has the highest priority.
module arb4_sched #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  arb4_sched_if.slave  bus
);

  localparam int            CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] hold_q, hold_d;

  logic          win_found;
  logic [1:0]    win_idx;

`ifdef ROUND_ROBIN_EN
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    req_rot;
  logic [1:0]    rot_pos;

  // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
  always_comb begin
    req_rot   = 4'({bus.req, bus.req} >> ptr_q);
    rot_pos   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) rot_pos = 2'(i);
    end
    win_found = |bus.req;
    win_idx   = ptr_q + rot_pos;
  end
`else
  always_comb begin
    win_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (bus.req[i]) win_idx = 2'(i);
    end
    win_found = |bus.req;
  end
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
`ifdef ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        gnt_d   = 4'b0000;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        hold_d  = '0;
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = CW'(1);
        end
      end
      GRANT: begin
        if (!bus.req[idx_q] || hold_q == HOLD_MAX) begin
          // An owner dropping on the limit cycle counts as a normal release.
          timeout_d = bus.req[idx_q];
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          idx_d     = 2'd0;
          valid_d   = 1'b0;
          hold_d    = '0;
`ifdef ROUND_ROBIN_EN
          ptr_d     = idx_q + 2'd1;
`endif
        end else begin
          hold_d = hold_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        idx_d   = 2'd0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      idx_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule
